mem_arbiter: RTL

- Two-port arbiter between the instruction cache, the data cache and the single shared 128-bit memory bus.
- Each cache sees a private memory port with the same level-request / ready-pulse handshake the caches already speak.
- The arbiter serialises requests with round-robin fairness and latches address and data at grant.
- It hides the one-cycle request-drop lag of the caches, so no stale request is re-issued to memory.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the three private ports around the shared memory arbiter:
// the I-cache port, the D-cache port and the single 128-bit memory bus.
// The slave modport is the arbiter's view, the master modport is the
// environment's view (the caches plus the memory controller).
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    // I-cache port
    logic              icache_read;
    logic [ADDR_W-1:0] icache_addr;
    logic [DATA_W-1:0] icache_rdata;
    logic              icache_ready;

    // D-cache port
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_addr;
    logic [DATA_W-1:0] dcache_wdata;
    logic [DATA_W-1:0] dcache_rdata;
    logic              dcache_ready;

    // Shared memory bus
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  icache_read, icache_addr,
        output icache_rdata, icache_ready,
        input  dcache_read, dcache_write, dcache_addr, dcache_wdata,
        output dcache_rdata, dcache_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output icache_read, icache_addr,
        input  icache_rdata, icache_ready,
        output dcache_read, dcache_write, dcache_addr, dcache_wdata,
        input  dcache_rdata, dcache_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the I-cache and the D-cache for one shared
// block-wide memory bus. A request is granted in IDLE, its address, data
// and operation are latched, and the memory bus is driven only from those
// latched values. After each completion the arbiter spends one DONE cycle
// ignoring the finished requester, because the caches drop their level
// request one cycle after seeing the ready pulse; without that cycle the
// stale request would be granted a second time.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic             clk,
    input  logic             proc_reset,
    mem_arbiter_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        DONE_I  = 3'd3,
        DONE_D  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // last_d = 1 when the most recent grant went to the D-cache
    logic              last_d;
    logic              last_d_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_nxt;
    // op_wr_q = 1 for a write-back, 0 for a block read
    logic              op_wr_q;
    logic              op_wr_nxt;

    logic              i_req;
    logic              d_req;
    logic              grant_i;
    logic              grant_d;

    assign i_req = bus.icache_read;
    assign d_req = bus.dcache_read | bus.dcache_write;

    // With both sides asking, the side that was not served last wins.
    assign grant_i = i_req & (~d_req | last_d);
    assign grant_d = d_req & (~i_req | ~last_d);

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state   <= IDLE;
            last_d  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            last_d  <= last_d_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            op_wr_q <= op_wr_nxt;
        end
    end

    // Next-state, grant latching and memory request decode
    always_comb begin
        state_nxt     = state;
        last_d_nxt    = last_d;
        addr_nxt      = addr_q;
        wdata_nxt     = wdata_q;
        op_wr_nxt     = op_wr_q;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;

        case (state)
            IDLE: begin
                if (grant_i) begin
                    state_nxt  = SERVE_I;
                    last_d_nxt = 1'b0;
                    addr_nxt   = bus.icache_addr;
                    op_wr_nxt  = 1'b0;
                end else if (grant_d) begin
                    state_nxt  = SERVE_D;
                    last_d_nxt = 1'b1;
                    addr_nxt   = bus.dcache_addr;
                    wdata_nxt  = bus.dcache_wdata;
                    // read and write together is illegal; the write wins
                    op_wr_nxt  = bus.dcache_write;
                end
            end
            SERVE_I: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt = DONE_I;
                end
            end
            SERVE_D: begin
                bus.mem_read  = ~op_wr_q;
                bus.mem_write = op_wr_q;
                if (bus.mem_ready) begin
                    state_nxt = DONE_D;
                end
            end
            DONE_I, DONE_D: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;

    // Ready pulses only reach the cache that currently owns the bus.
    assign bus.icache_ready = bus.mem_ready & (state == SERVE_I);
    assign bus.dcache_ready = bus.mem_ready & (state == SERVE_D);

    // Read data is broadcast; the ready pulse alone qualifies it.
    assign bus.icache_rdata = bus.mem_rdata;
    assign bus.dcache_rdata = bus.mem_rdata;

endmodule
